// File: rtl/symbol_interleaver_if.sv
// Symbol stream between the convolutional encoder, the block interleaver and
// the channel side. The encoder drives the master side and the interleaver
// uses the slave side.
interface symbol_interleaver_if;
    logic       valid_i;
    logic [1:0] d_in;
    logic       flush_i;
    logic       valid_o;
    logic [1:0] d_out;
    logic       sob_o;
    logic       busy_o;

    modport master (output valid_i, d_in, flush_i,
                    input  valid_o, d_out, sob_o, busy_o);
    modport slave  (input  valid_i, d_in, flush_i,
                    output valid_o, d_out, sob_o, busy_o);
endinterface

// File: rtl/symbol_interleaver.sv
// Ping-pong block interleaver for 2-bit encoder symbols. Symbols are written
// row-major into one bank while the other bank drains column-major, one
// symbol per cycle. A flush zero-pads the partial block so it can drain.
module symbol_interleaver #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    symbol_interleaver_if.slave  bus
);
    localparam int B  = ROWS * COLS;
    localparam int AW = $clog2(B);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [AW-1:0] LAST     = AW'(B - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    logic [1:0]    mem [2][B];
    logic          bank_sel;      // bank currently being written
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] wr_cnt_next;
    logic          pad_active;
    logic          pad_now;
    logic          wr_en;
    logic [1:0]    wr_data;
    logic          swap;

    rd_state_t     state;
    rd_state_t     state_next;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_idx_next;
    logic [RW-1:0] rd_row;
    logic [RW-1:0] rd_row_next;
    logic [CW-1:0] rd_col;
    logic [CW-1:0] rd_col_next;
    logic [AW-1:0] rd_addr;
    logic          busy;

    // Write-side decode: once padding starts it overrides valid_i until the block fills.
    // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pad_now     = pad_active || (bus.flush_i && (wr_cnt != '0));
        wr_en       = pad_now || bus.valid_i;
        wr_data     = pad_now ? 2'b00 : bus.d_in;
        swap        = wr_en && (wr_cnt == LAST);
        wr_cnt_next = wr_cnt;
        if (swap) begin
            wr_cnt_next = '0;
        end else if (wr_en) begin
            wr_cnt_next = wr_cnt + AW'(1);
        end
    end

    // Symbol storage for both banks.
    // NOTE: the banks have no reset; a block is always fully written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[bank_sel][wr_cnt] <= wr_data;
        end
    end

    // Write counter, bank select and padding flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            bank_sel   <= 1'b0;
            pad_active <= 1'b0;
        end else begin
            wr_cnt <= wr_cnt_next;
            if (swap) begin
                bank_sel   <= ~bank_sel;
                pad_active <= 1'b0;
            end else if (pad_now) begin
                pad_active <= 1'b1;
            end
        end
    end

    // Read FSM next state: drain B symbols column-major, restarting seamlessly on a swap.
    always_comb begin
        state_next  = state;
        rd_idx_next = rd_idx;
        rd_row_next = rd_row;
        rd_col_next = rd_col;
        case (state)
            R_IDLE: begin
                if (swap) begin
                    state_next  = R_DRAIN;
                    rd_idx_next = '0;
                    rd_row_next = '0;
                    rd_col_next = '0;
                end
            end
            R_DRAIN: begin
                if (rd_idx == LAST) begin
                    rd_idx_next = '0;
                    rd_row_next = '0;
                    rd_col_next = '0;
                    if (!swap) begin
                        state_next = R_IDLE;
                    end
                end else begin
                    rd_idx_next = rd_idx + AW'(1);
                    if (rd_row == ROW_LAST) begin
                        rd_row_next = '0;
                        rd_col_next = rd_col + CW'(1);
                    end else begin
                        rd_row_next = rd_row + RW'(1);
                    end
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    // Read FSM registers and the registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= R_IDLE;
            rd_idx <= '0;
            rd_row <= '0;
            rd_col <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            rd_idx <= rd_idx_next;
            rd_row <= rd_row_next;
            rd_col <= rd_col_next;
            busy   <= (wr_cnt_next != '0) || (state_next == R_DRAIN);
        end
    end

    assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

    // Output stage: the read bank is the one not being written; quiet zeros when idle.
    always_comb begin
        bus.valid_o = 1'b0;
        bus.sob_o   = 1'b0;
        bus.d_out   = 2'b00;
        if (state == R_DRAIN) begin
            bus.valid_o = 1'b1;
            bus.sob_o   = (rd_idx == '0);
            bus.d_out   = mem[~bank_sel][rd_addr];
        end
    end

    assign bus.busy_o = busy;
endmodule

// File: tb/tb_symbol_interleaver.sv
// Self-checking bench for symbol_interleaver with a 4x4 block. A queue-based
// reference model collects written symbols into blocks and, on completion,
// queues the column-major output sequence for the following cycles.
module tb_symbol_interleaver;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int B    = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    symbol_interleaver_if bus();

    symbol_interleaver #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state.
    logic [1:0] wblk[$];        // symbols of the block being written
    bit         padding = 1'b0;
    logic [2:0] drain_q[$];     // {sob, d} still to be shown, front is shown now

    // Observed valid outputs of the current scenario.
    logic [1:0] obs_d[$];
    logic       obs_sob[$];

    // Expected column-major read order for a 4x4 block.
    int order[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    function automatic logic [4:0] exp_vec();
        logic busy_e;
        busy_e = (wblk.size() != 0) || (drain_q.size() != 0);
        if (drain_q.size() != 0) return {1'b1, drain_q[0], busy_e};
        return {4'b0000, busy_e};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {bus.valid_o, bus.sob_o, bus.d_out, bus.busy_o};
    endfunction

    // Apply one cycle of inputs, advance the model on the edge, sample at negedge.
    task automatic drive_edge(input bit r, input bit v, input logic [1:0] d, input bit f);
        rst         = r;
        bus.valid_i = v;
        bus.d_in    = d;
        bus.flush_i = f;
        @(posedge clk);
        if (r) begin
            wblk.delete();
            drain_q.delete();
            padding = 1'b0;
        end else begin
            if (drain_q.size() != 0) void'(drain_q.pop_front());
            if (padding || (f && wblk.size() != 0)) begin
                wblk.push_back(2'b00);
                padding = 1'b1;
            end else if (v) begin
                wblk.push_back(d);
            end
            if (wblk.size() == B) begin
                for (int j = 0; j < B; j++)
                    drain_q.push_back({(j == 0), wblk[(j % ROWS) * COLS + j / ROWS]});
                wblk.delete();
                padding = 1'b0;
            end
        end
        @(negedge clk);
        if (bus.valid_o) begin
            obs_d.push_back(bus.d_out);
            obs_sob.push_back(bus.sob_o);
        end
        cyc++;
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_sob.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b1, 2'(i), 1'b1);
            n_vec++;
            if (obs_vec() !== 5'b00000) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %b expected 00000", cyc, obs_vec());
            end
        end
        drive_edge(1'b0, 1'b0, 2'b00, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_release cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_block();
        logic [1:0] s[16];
        clear_obs();
        foreach (s[i]) s[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 16 + 20; i++) begin
            if (i < 16) drive_edge(1'b0, 1'b1, s[i], 1'b0);
            else        drive_edge(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_block cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (obs_d.size() != 16) begin
            n_err++;
            $display("FAIL single_block_count: got %0d outputs expected 16", obs_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_vec++;
                if (obs_d[k] !== s[order[k]] || obs_sob[k] !== (k == 0)) begin
                    n_err++;
                    $display("FAIL single_block_order k=%0d: got d=%b sob=%b expected d=%b sob=%b",
                             k, obs_d[k], obs_sob[k], s[order[k]], (k == 0));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        for (int i = 0; i < 48 + 20; i++) begin
            if (i < 48) drive_edge(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            else        drive_edge(1'b0, 1'b0, 2'b00, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (obs_d.size() != 48) begin
            n_err++;
            $display("FAIL back_to_back_count: got %0d outputs expected 48", obs_d.size());
        end else begin
            for (int k = 0; k < 48; k++) begin
                if (obs_sob[k] !== (k % 16 == 0)) begin
                    n_err++;
                    $display("FAIL back_to_back_sob k=%0d: got %b expected %b", k, obs_sob[k], (k % 16 == 0));
                end
            end
        end
    endtask

    task automatic test_gapped();
        logic [1:0] s[16];
        clear_obs();
        foreach (s[i]) s[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 32 + 20; i++) begin
            if (i < 32 && i % 2 == 0) drive_edge(1'b0, 1'b1, s[i / 2], 1'b0);
            else                      drive_edge(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL gapped cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (obs_d.size() != 16) begin
            n_err++;
            $display("FAIL gapped_count: got %0d outputs expected 16", obs_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (obs_d[k] !== s[order[k]]) begin
                    n_err++;
                    $display("FAIL gapped_order k=%0d: got %b expected %b", k, obs_d[k], s[order[k]]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [1:0] s[5];
        int         fidx[16] = '{0, 4, -1, -1, 1, -1, -1, -1, 2, -1, -1, -1, 3, -1, -1, -1};
        logic [1:0] e;
        clear_obs();
        foreach (s[i]) s[i] = 2'($urandom_range(1, 3));
        // Flush with nothing held must be ignored, then 5 symbols, a flush pulse
        // carrying a junk valid symbol, and idle cycles while padding completes.
        for (int i = 0; i < 2 + 5 + 1 + 35; i++) begin
            if (i < 2)           drive_edge(1'b0, 1'b0, 2'b00, 1'b1);
            else if (i < 7)      drive_edge(1'b0, 1'b1, s[i - 2], 1'b0);
            else if (i == 7)     drive_edge(1'b0, 1'b1, 2'b11, 1'b1);
            else                 drive_edge(1'b0, 1'($urandom_range(0, 1)), 2'b11, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL flush cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
            if (i == 17) break;  // stop right after padding so later valid_i starts no new block early
        end
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b0, 1'b0, 2'b00, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL flush_drain cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (obs_d.size() != 16) begin
            n_err++;
            $display("FAIL flush_count: got %0d outputs expected 16", obs_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                e = (fidx[k] < 0) ? 2'b00 : s[fidx[k]];
                if (obs_d[k] !== e) begin
                    n_err++;
                    $display("FAIL flush_order k=%0d: got %b expected %b", k, obs_d[k], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [1:0] s[16];
        for (int i = 0; i < 16 + 6; i++) begin
            drive_edge(1'b0, (i < 16), 2'($urandom_range(0, 3)), 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL pre_reset cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        drive_edge(1'b1, 1'b1, 2'b10, 1'b1);
        n_vec++;
        if (obs_vec() !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_mid_drain cyc %0d: got %b expected 00000", cyc, obs_vec());
        end
        clear_obs();
        foreach (s[i]) s[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 16 + 20; i++) begin
            drive_edge(1'b0, (i < 16), (i < 16) ? s[i] : 2'b00, 1'b0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (obs_d.size() != 16) begin
            n_err++;
            $display("FAIL post_reset_count: got %0d outputs expected 16", obs_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (obs_d[k] !== s[order[k]]) begin
                    n_err++;
                    $display("FAIL post_reset_order k=%0d: got %b expected %b", k, obs_d[k], s[order[k]]);
                end
            end
        end
    endtask

    task automatic test_burst();
        clear_obs();
        for (int i = 0; i < 16 + 20; i++) begin
            drive_edge(1'b0, (i < 16), (i == 4) ? 2'b01 : (i == 8) ? 2'b10 : 2'b00, 1'b0);
        end
        n_vec++;
        if (obs_d.size() != 16 || obs_d[1] !== 2'b01 || obs_d[2] !== 2'b10) begin
            n_err++;
            $display("FAIL burst_spread: got count=%0d out1=%b out2=%b expected count=16 out1=01 out2=10",
                     obs_d.size(), (obs_d.size() > 2) ? obs_d[1] : 2'bxx, (obs_d.size() > 2) ? obs_d[2] : 2'bxx);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k != 1 && k != 2 && obs_d[k] !== 2'b00) begin
                    n_err++;
                    $display("FAIL burst_zero k=%0d: got %b expected 00", k, obs_d[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            drive_edge($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0,
                       2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 40; i++) begin
            drive_edge(1'b0, 1'b0, 2'b00, (i == 0));
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_drain cyc %0d: got %b expected %b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.d_in    = 2'b00;
        bus.flush_i = 1'b0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_gapped();
        test_flush();
        test_reset_mid_drain();
        test_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
